llc_arbiter: RTL and testbench
==============================

Name: llc_arbiter

Overview:
- Two-client arbiter between the split I-cache and D-cache and the single lowest-level-cache port of the cacheline adaptor.
- Grants one 256-bit line transaction at a time and latches the address and write data for its full duration.
- Issues a level read/write command downstream, holds it until the downstream response, then returns the line and a one-cycle response to the granted client.

Parameters:
- ADDR_W, 32, address width for both clients and downstream.
- LINE_W, 256, cache line width.
- OFFSET_W, 5, low address bits forced to zero on address_o (line alignment).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- i_address_i  in  ADDR_W  I-cache line address.
- i_read_i  in  1  I-cache read request; level, held until i_resp_o.
- i_line_o  out  LINE_W  line returned to I-cache.
- i_resp_o  out  1  I-cache completion pulse.
- d_address_i  in  ADDR_W  D-cache line address.
- d_read_i  in  1  D-cache read request; level.
- d_write_i  in  1  D-cache writeback request; level.
- d_line_i  in  LINE_W  D-cache writeback data.
- d_line_o  out  LINE_W  line returned to D-cache.
- d_resp_o  out  1  D-cache completion pulse.
- address_o  out  ADDR_W  downstream address, registered.
- read_o  out  1  downstream read, registered.
- write_o  out  1  downstream write, registered.
- line_o  out  LINE_W  downstream write data, registered.
- line_i  in  LINE_W  downstream read data, valid with resp_i.
- resp_i  in  1  downstream completion, single cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = I.
- States: IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE.
- IDLE:
  - d_req = d_read_i | d_write_i.
  - Only i_read_i pending: go to I_BUSY.
  - Only d_req pending: go to D_BUSY.
  - Both pending: grant the client not equal to last_grant, so the first simultaneous request after reset goes to D and later contention alternates.
  - On grant: address_o <= {addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}; update last_grant.
  - I grant: read_o <= 1.
  - D grant with d_write_i=1: write_o <= 1 and line_o <= d_line_i. Write wins if d_read_i and d_write_i are both high.
  - D grant otherwise: read_o <= 1.
- *_BUSY:
  - read_o/write_o, address_o and line_o are held constant.
  - Client input changes are ignored; a client that drops its request mid-transaction still gets the transaction completed and its resp pulsed.
  - On resp_i: clear read_o/write_o (registered, low in the next cycle); capture line_i into i_line_o or d_line_o (read only; on write the client line output keeps its previous value); go to *_DONE.
  - resp_i outside a BUSY state is ignored.
- *_DONE:
  - The granted client's resp_o is high for exactly this one cycle.
  - Next state is always IDLE, so the downstream command is low for at least 2 cycles between transactions and the adaptor cannot re-trigger on a stale command.
- Latency:
  - Request sampled at edge E0 in IDLE; read_o/write_o high from E0 through the edge that samples resp_i (E_r).
  - Client resp high in cycle E_r+1.
  - Earliest next grant at edge E_r+2.
- i_resp_o and d_resp_o are never high together.
- Client line outputs hold their value until the next read for that client.
- Reset asserted mid-transaction: immediately return to IDLE with all outputs 0. The downstream adaptor shares the reset and also restarts.

Test Plan:
- I read alone, addr 0x0000_1234, downstream resp_i 5 cycles after read_o -> address_o=0x0000_1220; read_o high until resp_i edge; i_line_o=line_i; i_resp_o pulsed 1 cycle; d_resp_o stays 0.
- D write, addr 0x8000_0040, d_line_i=256'hA5..A5 -> write_o high, line_o=A5..A5 stable for the whole transaction, d_resp_o pulse, d_line_o unchanged.
- I and D read requested in the same cycle after reset, both held -> D served first, then I. On re-request of both, D is served first again (alternation preserved); each resp pulses once.
- D asserts read and write together -> write_o=1, read_o=0 throughout.
- Client drops i_read_i mid-BUSY and d_address_i toggles -> address_o unchanged, transaction completes, i_resp_o still pulses.
- rst asserted asynchronously during D_BUSY -> read_o/write_o/line_o/address_o go 0 without a clock edge; next request is granted normally.

Source files
------------

// File: rtl/llc_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto the single LLC port of the cacheline adaptor.
// One line transaction at a time; downstream command and payload are registered and held until resp_i.
module llc_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address_i,
  input  logic              i_read_i,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp_o,
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [LINE_W-1:0] line_o,
  input  logic [LINE_W-1:0] line_i,
  input  logic              resp_i
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'(1) << OFFSET_W) - 64'(1));

  typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE} state_t;

  state_t            state, state_next;
  logic              last_d, last_d_next;
  logic [ADDR_W-1:0] address_next;
  logic              read_next, write_next;
  logic [LINE_W-1:0] line_next, i_line_next, d_line_next;
  logic              i_resp_next, d_resp_next;
  logic              d_req, grant_d, grant_i;

  // On contention the client that did not win last time is granted.
  assign d_req   = d_read_i | d_write_i;
  assign grant_d = d_req && (!i_read_i || !last_d);
  assign grant_i = i_read_i && (!d_req || last_d);

  always_comb begin
    state_next   = state;
    last_d_next  = last_d;
    address_next = address_o;
    read_next    = read_o;
    write_next   = write_o;
    line_next    = line_o;
    i_line_next  = i_line_o;
    d_line_next  = d_line_o;
    i_resp_next  = 1'b0;
    d_resp_next  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next   = D_BUSY;
          last_d_next  = 1'b1;
          address_next = d_address_i & ALIGN_MASK;
          if (d_write_i) begin
            write_next = 1'b1;
            line_next  = d_line_i;
          end else begin
            read_next = 1'b1;
          end
        end else if (grant_i) begin
          state_next   = I_BUSY;
          last_d_next  = 1'b0;
          address_next = i_address_i & ALIGN_MASK;
          read_next    = 1'b1;
        end
      end
      I_BUSY: begin
        if (resp_i) begin
          state_next  = I_DONE;
          read_next   = 1'b0;
          write_next  = 1'b0;
          i_line_next = line_i;
          i_resp_next = 1'b1;
        end
      end
      D_BUSY: begin
        if (resp_i) begin
          state_next  = D_DONE;
          read_next   = 1'b0;
          write_next  = 1'b0;
          d_resp_next = 1'b1;
          // Writebacks leave the client's line output untouched.
          if (read_o) d_line_next = line_i;
        end
      end
      // Forced pass through IDLE keeps the command low for two cycles between transactions.
      I_DONE:  state_next = IDLE;
      D_DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      line_o    <= '0;
      i_line_o  <= '0;
      d_line_o  <= '0;
      i_resp_o  <= 1'b0;
      d_resp_o  <= 1'b0;
    end else begin
      state     <= state_next;
      last_d    <= last_d_next;
      address_o <= address_next;
      read_o    <= read_next;
      write_o   <= write_next;
      line_o    <= line_next;
      i_line_o  <= i_line_next;
      d_line_o  <= d_line_next;
      i_resp_o  <= i_resp_next;
      d_resp_o  <= d_resp_next;
    end
  end

endmodule

// File: tb/tb_llc_arbiter.sv
// Bench for llc_arbiter: vector table of single-client transactions plus hand sequences for
// contention, request drop, and asynchronous reset; a queue holds expected downstream transactions.
module tb_llc_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_address_i, d_address_i, address_o;
  logic              i_read_i, d_read_i, d_write_i;
  logic [LINE_W-1:0] i_line_o, d_line_o, d_line_i, line_o, line_i;
  logic              i_resp_o, d_resp_o, read_o, write_o, resp_i;

  llc_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address_i(i_address_i), .i_read_i(i_read_i), .i_line_o(i_line_o), .i_resp_o(i_resp_o),
    .d_address_i(d_address_i), .d_read_i(d_read_i), .d_write_i(d_write_i), .d_line_i(d_line_i),
    .d_line_o(d_line_o), .d_resp_o(d_resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .line_o(line_o),
    .line_i(line_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              is_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  typedef struct {
    logic              is_d;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rdata;
    int                lat;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  exp_t              sb[$];
  vec_t              vecs[5];
  int                checks = 0;
  int                errors = 0;
  logic [LINE_W-1:0] m_i_line, m_d_line;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Drive a client request and record the downstream transaction it must produce.
  task automatic request(input logic is_d, input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wline, input logic [LINE_W-1:0] rdata,
                         input logic [ADDR_W-1:0] exp_addr);
    exp_t e;
    if (is_d) begin
      d_address_i = addr; d_read_i = rd; d_write_i = wr; d_line_i = wline;
    end else begin
      i_address_i = addr; i_read_i = 1'b1;
    end
    e.is_d = is_d; e.wr = is_d & wr; e.addr = exp_addr; e.wline = wline; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Downstream model: wait for a command, compare to the queue head, hold, respond, check completion.
  task automatic serve(input int lat, input bit drop);
    exp_t e;
    bit   got;
    int   waited;
    got = 1'b0;
    waited = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (read_o || write_o) begin got = 1'b1; waited = n; break; end
    end
    if (!got) begin fail_now("grant_timeout"); return; end
    if (sb.size() == 0) begin fail_now("unexpected_command"); return; end
    e = sb.pop_front();
    check("grant_latency", LINE_W'(waited), '0);
    check("address_o", address_o, e.addr);
    check("read_o", read_o, !e.wr);
    check("write_o", write_o, e.wr);
    if (e.wr) check("line_o", line_o, e.wline);
    for (int k = 1; k < lat; k++) begin
      if (drop && k == 1) begin
        i_read_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0; d_address_i = ~d_address_i;
      end
      @(negedge clk);
      check("hold_address", address_o, e.addr);
      check("hold_cmd", {read_o, write_o}, {!e.wr, e.wr});
      if (e.wr) check("hold_line", line_o, e.wline);
      check("busy_resp", {i_resp_o, d_resp_o}, '0);
    end
    resp_i = 1'b1;
    line_i = e.rdata;
    @(negedge clk);
    resp_i = 1'b0;
    line_i = '0;
    if (!e.wr) begin
      if (e.is_d) m_d_line = e.rdata; else m_i_line = e.rdata;
    end
    check("i_resp_o", i_resp_o, !e.is_d);
    check("d_resp_o", d_resp_o, e.is_d);
    check("cmd_cleared", {read_o, write_o}, '0);
    check("i_line_o", i_line_o, m_i_line);
    check("d_line_o", d_line_o, m_d_line);
    if (e.is_d) begin d_read_i = 1'b0; d_write_i = 1'b0; end else i_read_i = 1'b0;
    @(negedge clk);
    check("resp_one_cycle", {i_resp_o, d_resp_o}, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_i_line = '0;
    m_d_line = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, '0, {8{32'hCAFE_0001}}, 5, 32'h0000_1220};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h8000_0040, {32{8'hA5}}, {8{32'hDEAD_0002}}, 3, 32'h8000_0040};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_107F, {32{8'h5A}}, {8{32'hBEEF_0003}}, 2, 32'h0000_1060};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, '0, {8{32'h1234_5678}}, 1, 32'hFFFF_FFE0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_001F, '0, {8{32'h0BAD_F00D}}, 1, 32'h0000_0000};

    i_address_i = '0; i_read_i = 1'b0;
    d_address_i = '0; d_read_i = 1'b0; d_write_i = 1'b0; d_line_i = '0;
    line_i = '0; resp_i = 1'b0;
    do_reset();

    check("reset_outputs", {address_o, read_o, write_o, i_resp_o, d_resp_o}, '0);
    check("reset_lines", line_o | i_line_o | d_line_o, '0);

    // Stray response while idle must have no effect.
    resp_i = 1'b1; line_i = {32{8'hFF}};
    @(negedge clk);
    resp_i = 1'b0; line_i = '0;
    @(negedge clk);
    check("idle_resp_ignored", {read_o, write_o, i_resp_o, d_resp_o}, '0);
    check("idle_resp_lines", i_line_o | d_line_o, '0);

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      request(vecs[v].is_d, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wline, vecs[v].rdata,
              vecs[v].exp_addr);
      serve(vecs[v].lat, 1'b0);
    end

    // Simultaneous requests after reset: D first, then I; re-request gives D first again.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      request(1'b1, 1'b1, 1'b0, 32'h0000_2204, '0, {8{32'hD000_0000 + 32'(r)}}, 32'h0000_2200);
      request(1'b0, 1'b1, 1'b0, 32'h0000_3308, '0, {8{32'hE000_0000 + 32'(r)}}, 32'h0000_3300);
      serve(2, 1'b0);
      serve(3, 1'b0);
    end

    // Client withdraws and D address wiggles mid-transaction; the transaction still completes.
    @(negedge clk);
    request(1'b0, 1'b1, 1'b0, 32'h2000_0044, '0, {8{32'h7777_1111}}, 32'h2000_0040);
    serve(4, 1'b1);

    // Asynchronous reset during D_BUSY clears outputs without a clock edge.
    @(negedge clk);
    request(1'b1, 1'b0, 1'b1, 32'h0000_3000, {32{8'h3C}}, '0, 32'h0000_3000);
    @(negedge clk);
    check("pre_reset_write", write_o, 1'b1);
    void'(sb.pop_back());
    #2 rst = 1'b1;
    #1;
    check("async_rst_cmd", {read_o, write_o}, '0);
    check("async_rst_address", address_o, '0);
    check("async_rst_line", line_o, '0);
    check("async_rst_lines", i_line_o | d_line_o, '0);
    m_i_line = '0;
    m_d_line = '0;
    d_write_i = 1'b0; d_read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    request(1'b1, 1'b1, 1'b0, 32'h0000_4444, '0, {8{32'h4444_4444}}, 32'h0000_4440);
    serve(3, 1'b0);

    if (sb.size() != 0) fail_now("scoreboard_not_empty");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
